// File: rtl/cpu_hazard_ctrl_if.sv
// Signal bundle between the five-stage pipeline registers and the hazard controller.
// The pipeline (master) supplies stage fields; the controller (slave) returns enables, flushes and selects.
interface cpu_hazard_ctrl_if;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic [4:0]  idex_rs;
  logic [4:0]  idex_rt;
  logic        idex_regwr;
  logic        idex_memrd;
  logic [4:0]  idex_addrc;
  logic        exmem_regwr;
  logic [4:0]  exmem_addrc;
  logic        memwb_regwr;
  logic [4:0]  memwb_addrc;
  logic [2:0]  pcsrc_id;
  logic        branch_ex;
  logic        irq_in;
  logic        kernelpc;
  logic        cntclr;

  logic        pc_wr;
  logic        ifid_wr;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  fwda;
  logic [1:0]  fwdb;
  logic        irq_take;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output ifid_rs, ifid_rt, idex_rs, idex_rt, idex_regwr, idex_memrd, idex_addrc,
           exmem_regwr, exmem_addrc, memwb_regwr, memwb_addrc, pcsrc_id,
           branch_ex, irq_in, kernelpc, cntclr,
    input  pc_wr, ifid_wr, ifid_flush, idex_flush, fwda, fwdb, irq_take,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_regwr, idex_memrd, idex_addrc,
           exmem_regwr, exmem_addrc, memwb_regwr, memwb_addrc, pcsrc_id,
           branch_ex, irq_in, kernelpc, cntclr,
    output pc_wr, ifid_wr, ifid_flush, idex_flush, fwda, fwdb, irq_take,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/cpu_hazard_ctrl.sv
// Hazard, forwarding and interrupt-entry controller for the five-stage pipeline,
// with saturating stall/flush cycle counters for performance debug.
module cpu_hazard_ctrl (
  input  logic             clk,
  input  logic             reset,
  cpu_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {IDLE, PEND, ENTER, SERV} irq_state_e;

  localparam logic [2:0] PC_PLUS4 = 3'd0;
  localparam logic [2:0] PC_J     = 3'd2;
  localparam logic [2:0] PC_JR    = 3'd3;
  localparam logic [2:0] PC_ILLOP = 3'd4;

  irq_state_e  state;
  logic        load_use;
  logic        jr_stall;
  logic        stall;
  logic        jump;
  logic        pc_wr;
  logic        ifid_wr;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  fwda;
  logic [1:0]  fwdb;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // EX/MEM wins over MEM/WB because it holds the younger result; $0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       em_wr, input logic [4:0] em_rd,
                                         input logic       mw_wr, input logic [4:0] mw_rd);
    if (em_wr && em_rd != 5'd0 && em_rd == src)      return 2'b01;
    else if (mw_wr && mw_rd != 5'd0 && mw_rd == src) return 2'b10;
    else                                             return 2'b00;
  endfunction

  assign load_use = hz.idex_memrd && hz.idex_addrc != 5'd0 &&
                    (hz.idex_addrc == hz.ifid_rs || hz.idex_addrc == hz.ifid_rt);
  assign jr_stall = hz.pcsrc_id == PC_JR && hz.ifid_rs != 5'd0 &&
                    ((hz.idex_regwr  && hz.idex_addrc  == hz.ifid_rs) ||
                     (hz.exmem_regwr && hz.exmem_addrc == hz.ifid_rs));
  assign stall    = load_use || jr_stall;
  assign jump     = hz.pcsrc_id == PC_J || hz.pcsrc_id == PC_JR || hz.pcsrc_id == PC_ILLOP;

  // NOTE: every output gets a default before the priority chain so no path leaves it unassigned (no latch).
  always_comb begin
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    fwda       = fwd_sel(hz.idex_rs, hz.exmem_regwr, hz.exmem_addrc, hz.memwb_regwr, hz.memwb_addrc);
    fwdb       = fwd_sel(hz.idex_rt, hz.exmem_regwr, hz.exmem_addrc, hz.memwb_regwr, hz.memwb_addrc);
    if (!reset) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
      fwda    = 2'b00;
      fwdb    = 2'b00;
    end else if (hz.branch_ex) begin
      // The ID instruction is squashed, so any stall or jump it asked for is moot.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state == ENTER) begin
      ifid_flush = 1'b1;
    end else if (stall) begin
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      idex_flush = 1'b1;
    end else if (jump) begin
      ifid_flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and the asynchronous reset only; no reset-less storage here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:  if (hz.irq_in && !hz.kernelpc) state <= PEND;
        PEND:  if (!hz.irq_in)                state <= IDLE;
               else if (!hz.branch_ex && !stall && !hz.kernelpc && hz.pcsrc_id == PC_PLUS4)
                                              state <= ENTER;
        ENTER:                                state <= SERV;
        SERV:  if (!hz.kernelpc && !hz.irq_in) state <= IDLE;
        default:                              state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else if (hz.cntclr) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (!pc_wr && stall_cnt != 16'hFFFF)                       stall_cnt <= stall_cnt + 16'd1;
      if ((ifid_flush || idex_flush) && flush_cnt != 16'hFFFF)  flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign hz.pc_wr      = pc_wr;
  assign hz.ifid_wr    = ifid_wr;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_flush = idex_flush;
  assign hz.fwda       = fwda;
  assign hz.fwdb       = fwdb;
  assign hz.irq_take   = (state == ENTER);
  assign hz.stall_cnt  = stall_cnt;
  assign hz.flush_cnt  = flush_cnt;

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Directed bench for cpu_hazard_ctrl: forwarding, stalls, flushes, interrupt entry, counters.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_cpu_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_stall = 16'd0;
  logic [15:0] exp_flush = 16'd0;

  cpu_hazard_ctrl_if hif();
  cpu_hazard_ctrl dut (.clk(clk), .reset(reset), .hz(hif));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    hif.ifid_rs = 0; hif.ifid_rt = 0; hif.idex_rs = 0; hif.idex_rt = 0;
    hif.idex_regwr = 0; hif.idex_memrd = 0; hif.idex_addrc = 0;
    hif.exmem_regwr = 0; hif.exmem_addrc = 0; hif.memwb_regwr = 0; hif.memwb_addrc = 0;
    hif.pcsrc_id = 0; hif.branch_ex = 0; hif.irq_in = 0; hif.kernelpc = 0; hif.cntclr = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    hif.exmem_regwr = 1; hif.exmem_addrc = 5; hif.idex_rs = 5; hif.branch_ex = 1;
    @(negedge clk); #1;
    total++; if (hif.pc_wr !== 1'b0) begin bad++; $display("FAIL rst_pc_wr got=%b want=0", hif.pc_wr); end
    total++; if (hif.ifid_wr !== 1'b0) begin bad++; $display("FAIL rst_ifid_wr got=%b want=0", hif.ifid_wr); end
    total++; if ({hif.ifid_flush, hif.idex_flush} !== 2'b00) begin bad++; $display("FAIL rst_flush got=%b want=00", {hif.ifid_flush, hif.idex_flush}); end
    total++; if (hif.fwda !== 2'b00) begin bad++; $display("FAIL rst_fwda got=%b want=00", hif.fwda); end
    total++; if (hif.irq_take !== 1'b0) begin bad++; $display("FAIL rst_irq_take got=%b want=0", hif.irq_take); end
    total++; if ({hif.stall_cnt, hif.flush_cnt} !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%h/%h want=0/0", hif.stall_cnt, hif.flush_cnt); end
    hif.branch_ex = 0;
    reset = 1'b1; #1;
    total++; if ({hif.pc_wr, hif.ifid_wr} !== 2'b11) begin bad++; $display("FAIL rel_wr got=%b want=11", {hif.pc_wr, hif.ifid_wr}); end
    total++; if (hif.fwda !== 2'b01) begin bad++; $display("FAIL rel_fwda got=%b want=01", hif.fwda); end
    clear_inputs();
    tick();
  endtask

  task automatic test_forwarding();
    hif.exmem_regwr = 1; hif.exmem_addrc = 5; hif.memwb_regwr = 1; hif.memwb_addrc = 5;
    hif.idex_rs = 5; hif.idex_rt = 5; #1;
    total++; if ({hif.fwda, hif.fwdb} !== 4'b0101) begin bad++; $display("FAIL fwd_both_exmem got=%b want=0101", {hif.fwda, hif.fwdb}); end
    hif.exmem_regwr = 0; #1;
    total++; if ({hif.fwda, hif.fwdb} !== 4'b1010) begin bad++; $display("FAIL fwd_memwb got=%b want=1010", {hif.fwda, hif.fwdb}); end
    hif.exmem_regwr = 1; hif.exmem_addrc = 0; hif.memwb_addrc = 0; hif.idex_rs = 0; hif.idex_rt = 0; #1;
    total++; if ({hif.fwda, hif.fwdb} !== 4'b0000) begin bad++; $display("FAIL fwd_r0 got=%b want=0000", {hif.fwda, hif.fwdb}); end
    hif.exmem_addrc = 3; hif.memwb_addrc = 7; hif.idex_rs = 3; hif.idex_rt = 7; #1;
    total++; if ({hif.fwda, hif.fwdb} !== 4'b0110) begin bad++; $display("FAIL fwd_split got=%b want=0110", {hif.fwda, hif.fwdb}); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    hif.idex_memrd = 1; hif.idex_regwr = 1; hif.idex_addrc = 8; hif.ifid_rs = 8; hif.ifid_rt = 8; #1;
    total++; if ({hif.pc_wr, hif.ifid_wr, hif.ifid_flush, hif.idex_flush} !== 4'b0001) begin bad++; $display("FAIL lu_stall got=%b want=0001", {hif.pc_wr, hif.ifid_wr, hif.ifid_flush, hif.idex_flush}); end
    exp_stall++; exp_flush++;
    tick();
    hif.idex_memrd = 0; hif.idex_regwr = 0; hif.idex_addrc = 0; hif.exmem_regwr = 1; hif.exmem_addrc = 8; #1;
    total++; if ({hif.pc_wr, hif.idex_flush} !== 2'b10) begin bad++; $display("FAIL lu_release got=%b want=10", {hif.pc_wr, hif.idex_flush}); end
    tick();
    hif.exmem_regwr = 0; hif.exmem_addrc = 0; hif.memwb_regwr = 1; hif.memwb_addrc = 8;
    hif.ifid_rs = 0; hif.ifid_rt = 0; hif.idex_rs = 8; hif.idex_rt = 8; #1;
    total++; if ({hif.fwda, hif.fwdb} !== 4'b1010) begin bad++; $display("FAIL lu_fwd got=%b want=1010", {hif.fwda, hif.fwdb}); end
    total++; if (hif.stall_cnt !== exp_stall) begin bad++; $display("FAIL lu_stallcnt got=%h want=%h", hif.stall_cnt, exp_stall); end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch_over_stall();
    hif.idex_memrd = 1; hif.idex_addrc = 8; hif.ifid_rs = 8; hif.pcsrc_id = 2; hif.branch_ex = 1; #1;
    total++; if ({hif.pc_wr, hif.ifid_flush, hif.idex_flush} !== 3'b111) begin bad++; $display("FAIL br_stall got=%b want=111", {hif.pc_wr, hif.ifid_flush, hif.idex_flush}); end
    exp_flush++;
    tick();
    clear_inputs(); #1;
    total++; if (hif.stall_cnt !== exp_stall) begin bad++; $display("FAIL br_stallcnt got=%h want=%h", hif.stall_cnt, exp_stall); end
    total++; if (hif.flush_cnt !== exp_flush) begin bad++; $display("FAIL br_flushcnt got=%h want=%h", hif.flush_cnt, exp_flush); end
  endtask

  task automatic test_jr_after_load();
    hif.idex_memrd = 1; hif.idex_regwr = 1; hif.idex_addrc = 31; hif.pcsrc_id = 3; hif.ifid_rs = 31; #1;
    total++; if ({hif.pc_wr, hif.ifid_flush, hif.idex_flush} !== 3'b001) begin bad++; $display("FAIL jr_c1 got=%b want=001", {hif.pc_wr, hif.ifid_flush, hif.idex_flush}); end
    exp_stall++; exp_flush++;
    tick();
    hif.idex_memrd = 0; hif.idex_regwr = 0; hif.idex_addrc = 0; hif.exmem_regwr = 1; hif.exmem_addrc = 31; #1;
    total++; if ({hif.pc_wr, hif.ifid_wr, hif.ifid_flush, hif.idex_flush} !== 4'b0001) begin bad++; $display("FAIL jr_c2 got=%b want=0001", {hif.pc_wr, hif.ifid_wr, hif.ifid_flush, hif.idex_flush}); end
    exp_stall++; exp_flush++;
    tick();
    hif.exmem_regwr = 0; hif.exmem_addrc = 0; hif.memwb_regwr = 1; hif.memwb_addrc = 31; #1;
    total++; if ({hif.pc_wr, hif.ifid_wr, hif.ifid_flush, hif.idex_flush} !== 4'b1110) begin bad++; $display("FAIL jr_c3 got=%b want=1110", {hif.pc_wr, hif.ifid_wr, hif.ifid_flush, hif.idex_flush}); end
    exp_flush++;
    tick();
    clear_inputs(); #1;
    total++; if (hif.stall_cnt !== exp_stall) begin bad++; $display("FAIL jr_stallcnt got=%h want=%h", hif.stall_cnt, exp_stall); end
    total++; if (hif.flush_cnt !== exp_flush) begin bad++; $display("FAIL jr_flushcnt got=%h want=%h", hif.flush_cnt, exp_flush); end
  endtask

  task automatic test_irq();
    hif.irq_in = 1; #1;
    total++; if (hif.irq_take !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b want=0", hif.irq_take); end
    tick();
    hif.pcsrc_id = 2; #1;
    total++; if ({hif.irq_take, hif.ifid_flush} !== 2'b01) begin bad++; $display("FAIL irq_blocked got=%b want=01", {hif.irq_take, hif.ifid_flush}); end
    exp_flush++;
    tick();
    hif.pcsrc_id = 0; #1;
    total++; if ({hif.irq_take, hif.ifid_flush} !== 2'b00) begin bad++; $display("FAIL irq_pend got=%b want=00", {hif.irq_take, hif.ifid_flush}); end
    tick();
    #1;
    total++; if ({hif.irq_take, hif.ifid_flush, hif.pc_wr} !== 3'b111) begin bad++; $display("FAIL irq_enter got=%b want=111", {hif.irq_take, hif.ifid_flush, hif.pc_wr}); end
    exp_flush++;
    tick();
    hif.kernelpc = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (hif.irq_take !== 1'b0) begin bad++; $display("FAIL irq_serv%0d got=%b want=0", i, hif.irq_take); end
      tick();
    end
    hif.kernelpc = 0; hif.irq_in = 0;
    tick();
    hif.irq_in = 1; hif.kernelpc = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      total++; if (hif.irq_take !== 1'b0) begin bad++; $display("FAIL irq_kernel%0d got=%b want=0", i, hif.irq_take); end
    end
    hif.kernelpc = 0;
    tick(); tick(); #1;
    total++; if (hif.irq_take !== 1'b1) begin bad++; $display("FAIL irq_second got=%b want=1", hif.irq_take); end
    exp_flush++;
    tick();
    clear_inputs();
    tick(); #1;
    total++; if (hif.flush_cnt !== exp_flush) begin bad++; $display("FAIL irq_flushcnt got=%h want=%h", hif.flush_cnt, exp_flush); end
  endtask

  task automatic test_reset_midflight();
    int n;
    n = 16'h1234 - int'(exp_stall);
    hif.idex_memrd = 1; hif.idex_addrc = 8; hif.ifid_rs = 8; hif.irq_in = 1;
    for (int i = 0; i < n; i++) tick();
    exp_stall = 16'h1234; exp_flush = exp_flush + 16'(n); #1;
    total++; if (hif.stall_cnt !== exp_stall) begin bad++; $display("FAIL mid_stallcnt got=%h want=%h", hif.stall_cnt, exp_stall); end
    total++; if (hif.flush_cnt !== exp_flush) begin bad++; $display("FAIL mid_flushcnt got=%h want=%h", hif.flush_cnt, exp_flush); end
    reset = 1'b0; #1;
    total++; if ({hif.irq_take, hif.pc_wr, hif.ifid_wr, hif.idex_flush} !== 4'b0000) begin bad++; $display("FAIL mid_rst_out got=%b want=0000", {hif.irq_take, hif.pc_wr, hif.ifid_wr, hif.idex_flush}); end
    total++; if ({hif.stall_cnt, hif.flush_cnt} !== 32'd0) begin bad++; $display("FAIL mid_rst_cnt got=%h/%h want=0/0", hif.stall_cnt, hif.flush_cnt); end
    exp_stall = 0; exp_flush = 0;
    tick();
    clear_inputs();
    reset = 1'b1;
    hif.irq_in = 1;
    tick(); #1;
    total++; if (hif.irq_take !== 1'b0) begin bad++; $display("FAIL mid_fsm_idle got=%b want=0", hif.irq_take); end
    tick(); #1;
    total++; if (hif.irq_take !== 1'b1) begin bad++; $display("FAIL mid_fsm_enter got=%b want=1", hif.irq_take); end
    exp_flush++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_saturation();
    hif.idex_memrd = 1; hif.idex_addrc = 8; hif.ifid_rt = 8;
    for (int i = 0; i < 65540; i++) tick();
    #1;
    total++; if (hif.stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_stall got=%h want=ffff", hif.stall_cnt); end
    total++; if (hif.flush_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_flush got=%h want=ffff", hif.flush_cnt); end
    hif.cntclr = 1;
    tick(); #1;
    total++; if ({hif.stall_cnt, hif.flush_cnt} !== 32'd0) begin bad++; $display("FAIL sat_clr got=%h/%h want=0/0", hif.stall_cnt, hif.flush_cnt); end
    hif.cntclr = 0;
    tick(); #1;
    total++; if ({hif.stall_cnt, hif.flush_cnt} !== {16'd1, 16'd1}) begin bad++; $display("FAIL sat_restart got=%h/%h want=1/1", hif.stall_cnt, hif.flush_cnt); end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_over_stall();
    test_jr_after_load();
    test_irq();
    test_reset_midflight();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
